// File: rtl/riscv_privileged_pkg.sv
// rtl/riscv_privileged_pkg.sv - privileged-architecture types shared by the CSR access path
//
// Purpose: CSR command encoding, Zicsr funct3 encoding, the CSR access
// sequencer state type and the illegal-instruction cause value.
package riscv_privileged_pkg;

  localparam int MXLEN = 32;

  typedef logic [11:0] csr_address_t;

  typedef enum logic [1:0] {
    NO_OPERATION = 2'b00,
    READ_ONLY    = 2'b01,
    WRITE_ONLY   = 2'b10,
    READ_WRITE   = 2'b11
  } csr_command_t;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_funct3_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    READ_WAIT = 3'd2,
    WRITE     = 3'd3,
    RESP      = 3'd4
  } csr_seq_state_t;

  localparam logic [MXLEN-1:0] CAUSE_ILLEGAL_INSTRUCTION = MXLEN'(2);

  // Addresses with [11:10] == 2'b11 are architecturally read-only.
  function automatic logic is_read_only_address(input csr_address_t address);
    return address[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// rtl/csr_rmw_alu.sv - new CSR value for the write phase of a Zicsr instruction
//
// Purpose: combinational read-modify-write value computation.
// Ports:
//   funct3_i     Zicsr funct3 (bit 2 selects the immediate operand)
//   old_value_i  value read from the CSR
//   rs1_data_i   register operand
//   uimm_i       5-bit zero-extended immediate operand
//   new_value_o  value to write back
module csr_rmw_alu
  import riscv_privileged_pkg::*;
(
  input  logic [2:0]       funct3_i,
  input  logic [MXLEN-1:0] old_value_i,
  input  logic [MXLEN-1:0] rs1_data_i,
  input  logic [4:0]       uimm_i,
  output logic [MXLEN-1:0] new_value_o
);

  logic [MXLEN-1:0] operand;

  always_comb begin
    operand = funct3_i[2] ? {{(MXLEN-5){1'b0}}, uimm_i} : rs1_data_i;
    case (funct3_i)
      CSRRS, CSRRSI: new_value_o = old_value_i | operand;
      CSRRC, CSRRCI: new_value_o = old_value_i & ~operand;
      default:       new_value_o = operand;
    endcase
  end

endmodule

// File: rtl/csr_access_sequencer.sv
// rtl/csr_access_sequencer.sv - sequences one Zicsr instruction into CSR read and write phases
//
// Purpose: accepts a decoded CSRRW/S/C(I) from execute, reads the CSR,
// writes the updated value, and returns the old value or an
// illegal-instruction exception to writeback.
// Ports:
//   clock_i, reset_ni                 clock, asynchronous active-low reset
//   flush_i                           kills a request still in its read phase
//   req_*                             request from execute (valid/ready)
//   csr_address_o/command_o/write_data_o  CSR file command port
//   csr_read_data_i/read_data_valid_i     CSR file response (data one cycle late)
//   rsp_*                             response to writeback (valid/ready)
module csr_access_sequencer
  import riscv_privileged_pkg::*;
#(
  parameter bit               READ_ONLY_CHECK_EN  = 1'b1,
  parameter logic [MXLEN-1:0] ILLEGAL_INSTR_CAUSE = CAUSE_ILLEGAL_INSTRUCTION
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [2:0]         req_funct3_i,
  input  logic [11:0]        req_address_i,
  input  logic [MXLEN-1:0]   req_rs1_data_i,
  input  logic [4:0]         req_uimm_i,
  input  logic               req_rd_zero_i,
  input  logic               req_rs1_zero_i,
  output logic [11:0]        csr_address_o,
  output csr_command_t       csr_command_o,
  output logic [MXLEN-1:0]   csr_write_data_o,
  input  logic [MXLEN-1:0]   csr_read_data_i,
  input  logic               csr_read_data_valid_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MXLEN-1:0]   rsp_rd_data_o,
  output logic               rsp_exception_o,
  output logic [MXLEN-1:0]   rsp_exception_cause_o
);

  csr_seq_state_t   state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [11:0]      address_q, address_d;
  logic [MXLEN-1:0] rs1_data_q, rs1_data_d;
  logic [4:0]       uimm_q, uimm_d;
  logic             rs1_zero_q, rs1_zero_d;
  logic [MXLEN-1:0] old_value_q, old_value_d;
  logic [MXLEN-1:0] write_data_q, write_data_d;
  logic             exception_q, exception_d;

  logic [2:0]       alu_funct3;
  logic [MXLEN-1:0] alu_old_value, alu_rs1_data, alu_new_value;
  logic [4:0]       alu_uimm;
  logic             req_illegal, req_is_write, latched_is_write;
  logic             req_read_only_fail, latched_read_only_fail;

  // In IDLE the ALU sees the incoming request so the skip-read path can
  // capture its write value at accept; afterwards it sees latched fields
  // and the freshly returned read data.
  always_comb begin
    if (state_q == IDLE) begin
      alu_funct3    = req_funct3_i;
      alu_old_value = '0;
      alu_rs1_data  = req_rs1_data_i;
      alu_uimm      = req_uimm_i;
    end else begin
      alu_funct3    = funct3_q;
      alu_old_value = csr_read_data_i;
      alu_rs1_data  = rs1_data_q;
      alu_uimm      = uimm_q;
    end
  end

  csr_rmw_alu u_rmw_alu (
    .funct3_i    (alu_funct3),
    .old_value_i (alu_old_value),
    .rs1_data_i  (alu_rs1_data),
    .uimm_i      (alu_uimm),
    .new_value_o (alu_new_value)
  );

  assign req_illegal            = req_funct3_i[1:0] == 2'b00;
  assign req_is_write           = req_funct3_i[1:0] == 2'b01;
  assign latched_is_write       = funct3_q[1:0] == 2'b01;
  assign req_read_only_fail     = READ_ONLY_CHECK_EN && is_read_only_address(req_address_i);
  assign latched_read_only_fail = READ_ONLY_CHECK_EN && is_read_only_address(address_q);

  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    address_d     = address_q;
    rs1_data_d    = rs1_data_q;
    uimm_d        = uimm_q;
    rs1_zero_d    = rs1_zero_q;
    old_value_d   = old_value_q;
    write_data_d  = write_data_q;
    exception_d   = exception_q;
    req_ready_o   = 1'b0;
    csr_command_o = NO_OPERATION;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && req_ready_o && !flush_i) begin
          funct3_d     = req_funct3_i;
          address_d    = req_address_i;
          rs1_data_d   = req_rs1_data_i;
          uimm_d       = req_uimm_i;
          rs1_zero_d   = req_rs1_zero_i;
          old_value_d  = '0;
          write_data_d = alu_new_value;
          exception_d  = 1'b0;
          if (req_illegal) begin
            state_d     = RESP;
            exception_d = 1'b1;
          end else if (req_is_write && req_rd_zero_i) begin
            // No read to fall back on, so the read-only check happens here.
            if (req_read_only_fail) begin
              state_d     = RESP;
              exception_d = 1'b1;
            end else begin
              state_d = WRITE;
            end
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        csr_command_o = READ_ONLY;
        if (flush_i) begin
          state_d = IDLE;
        end else if (!csr_read_data_valid_i) begin
          state_d     = RESP;
          exception_d = 1'b1;
        end else begin
          state_d = READ_WAIT;
        end
      end

      READ_WAIT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          old_value_d  = csr_read_data_i;
          write_data_d = alu_new_value;
          if (!latched_is_write && rs1_zero_q) begin
            state_d = RESP;
          end else if (latched_read_only_fail) begin
            state_d     = RESP;
            exception_d = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        // Committed: flush is not honoured from here on.
        csr_command_o = WRITE_ONLY;
        if (!csr_read_data_valid_i) begin
          exception_d = 1'b1;
        end
        state_d = RESP;
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      funct3_q     <= '0;
      address_q    <= '0;
      rs1_data_q   <= '0;
      uimm_q       <= '0;
      rs1_zero_q   <= 1'b0;
      old_value_q  <= '0;
      write_data_q <= '0;
      exception_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      address_q    <= address_d;
      rs1_data_q   <= rs1_data_d;
      uimm_q       <= uimm_d;
      rs1_zero_q   <= rs1_zero_d;
      old_value_q  <= old_value_d;
      write_data_q <= write_data_d;
      exception_q  <= exception_d;
    end
  end

  assign csr_address_o         = address_q;
  assign csr_write_data_o      = (state_q == WRITE) ? write_data_q : '0;
  assign rsp_valid_o           = state_q == RESP;
  assign rsp_rd_data_o         = (state_q == RESP && !exception_q) ? old_value_q : '0;
  assign rsp_exception_o       = state_q == RESP && exception_q;
  assign rsp_exception_cause_o = rsp_exception_o ? ILLEGAL_INSTR_CAUSE : '0;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// tb/tb_csr_access_sequencer.sv - self-checking bench for csr_access_sequencer
module tb_csr_access_sequencer;
  import riscv_privileged_pkg::*;

  logic         clock_i = 1'b0;
  logic         reset_ni = 1'b1;
  logic         flush_i = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [2:0]   req_funct3_i = '0;
  logic [11:0]  req_address_i = '0;
  logic [31:0]  req_rs1_data_i = '0;
  logic [4:0]   req_uimm_i = '0;
  logic         req_rd_zero_i = 1'b0;
  logic         req_rs1_zero_i = 1'b0;
  logic [11:0]  csr_address_o;
  csr_command_t csr_command_o;
  logic [31:0]  csr_write_data_o;
  logic [31:0]  csr_read_data_i = '0;
  logic         csr_read_data_valid_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [31:0]  rsp_rd_data_o;
  logic         rsp_exception_o;
  logic [31:0]  rsp_exception_cause_o;

  always #5 clock_i = ~clock_i;

  csr_access_sequencer dut (
    .clock_i               (clock_i),
    .reset_ni              (reset_ni),
    .flush_i               (flush_i),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_funct3_i          (req_funct3_i),
    .req_address_i         (req_address_i),
    .req_rs1_data_i        (req_rs1_data_i),
    .req_uimm_i            (req_uimm_i),
    .req_rd_zero_i         (req_rd_zero_i),
    .req_rs1_zero_i        (req_rs1_zero_i),
    .csr_address_o         (csr_address_o),
    .csr_command_o         (csr_command_o),
    .csr_write_data_o      (csr_write_data_o),
    .csr_read_data_i       (csr_read_data_i),
    .csr_read_data_valid_i (csr_read_data_valid_i),
    .rsp_valid_o           (rsp_valid_o),
    .rsp_ready_i           (rsp_ready_i),
    .rsp_rd_data_o         (rsp_rd_data_o),
    .rsp_exception_o       (rsp_exception_o),
    .rsp_exception_cause_o (rsp_exception_cause_o)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // CSR file environment: a few implemented CSRs, read data registered.
  function automatic bit env_exists(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'hF14};
  endfunction

  logic [31:0] csr_mem [0:4095] = '{default: 32'h0};

  assign csr_read_data_valid_i = env_exists(csr_address_o);

  always @(posedge clock_i) begin
    if (csr_command_o == READ_ONLY) csr_read_data_i <= csr_mem[csr_address_o];
    if (csr_command_o == WRITE_ONLY && env_exists(csr_address_o))
      csr_mem[csr_address_o] <= csr_write_data_o;
  end

  // Expected per-cycle outputs, filled in ahead of time by the model.
  typedef struct {
    bit          v;
    bit          ready;
    bit          rvalid;
    logic [1:0]  cmd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          exc;
  } exp_t;

  exp_t        exp_a [1024];
  exp_t        ce;
  logic [31:0] ref_mem [0:4095] = '{default: 32'h0};
  logic [31:0] last_rd;
  logic        last_exc;

  always @(negedge clock_i) begin
    ce = exp_a[cyc % 1024];
    if (ce.v) begin
      chk("req_ready", 32'(req_ready_o), 32'(ce.ready));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(ce.rvalid));
      chk("csr_command", 32'(csr_command_o), 32'(ce.cmd));
      if (ce.cmd != NO_OPERATION) chk("csr_address", 32'(csr_address_o), 32'(ce.addr));
      if (ce.cmd == WRITE_ONLY) chk("csr_write_data", csr_write_data_o, ce.wdata);
      if (ce.rvalid) begin
        chk("rsp_rd_data", rsp_rd_data_o, ce.rd);
        chk("rsp_exception", 32'(rsp_exception_o), 32'(ce.exc));
        chk("rsp_cause", rsp_exception_cause_o, ce.exc ? 32'd2 : 32'd0);
      end
    end
    if (rsp_valid_o && rsp_ready_i) begin
      last_rd  = rsp_rd_data_o;
      last_exc = rsp_exception_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_command"}, 32'(csr_command_o), 32'(NO_OPERATION));
    chk({tag, "_address"}, 32'(csr_address_o), 32'd0);
    chk({tag, "_write_data"}, csr_write_data_o, 32'd0);
    chk({tag, "_rd_data"}, rsp_rd_data_o, 32'd0);
    chk({tag, "_exception"}, 32'(rsp_exception_o), 32'd0);
    chk({tag, "_cause"}, rsp_exception_cause_o, 32'd0);
  endtask

  // One instruction: ISA-level model computes response, write and latency,
  // then the request is driven cycle by cycle. flush_at/reset_at name the
  // cycle (0 = presentation cycle) in which flush_i or a reset pulse lands.
  task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                        input logic [4:0] u, input bit rdz, input bit rsz,
                        input int bp, input int flush_at, input int reset_at);
    logic [1:0]  sched [8];
    logic [31:0] operand, oldv, newv, rd_exp;
    bit          exc, wr, is_w;
    int          lat, abort_k, end_k, c0;
    exp_t        e;

    for (int i = 0; i < 8; i++) sched[i] = NO_OPERATION;
    is_w    = (f3[1:0] == 2'b01);
    operand = f3[2] ? {27'b0, u} : rs1;
    oldv = '0; newv = operand; exc = 0; wr = 0;
    if (f3[1:0] == 2'b00) begin
      lat = 1; exc = 1;
    end else if (is_w && rdz) begin
      if (a[11:10] == 2'b11) begin
        lat = 1; exc = 1;
      end else begin
        lat = 2; sched[1] = WRITE_ONLY;
        if (env_exists(a)) wr = 1; else exc = 1;
      end
    end else begin
      sched[1] = READ_ONLY;
      if (!env_exists(a)) begin
        lat = 2; exc = 1;
      end else begin
        oldv = ref_mem[a];
        if (f3[1:0] == 2'b10)      newv = oldv | operand;
        else if (f3[1:0] == 2'b11) newv = oldv & ~operand;
        if (!is_w && rsz) lat = 3;
        else if (a[11:10] == 2'b11) begin lat = 3; exc = 1; end
        else begin lat = 4; sched[3] = WRITE_ONLY; wr = 1; end
      end
    end
    rd_exp = exc ? 32'd0 : oldv;

    abort_k = -1;
    if (flush_at == 0) abort_k = 0;
    else if (flush_at > 0 && flush_at < lat && sched[flush_at] != WRITE_ONLY) abort_k = flush_at;
    if (reset_at >= 0) abort_k = reset_at;
    end_k = (abort_k >= 0) ? abort_k + 1 : lat + bp + 1;
    if (wr && abort_k < 0) ref_mem[a] = newv;

    c0 = cyc;
    for (int k = 0; k <= end_k; k++) begin
      e.v = 1; e.addr = a; e.wdata = newv; e.rd = rd_exp; e.exc = exc;
      if (k == 0 || k == end_k || k == reset_at) begin
        e.ready = 1; e.rvalid = 0; e.cmd = NO_OPERATION;
      end else if (k < lat) begin
        e.ready = 0; e.rvalid = 0; e.cmd = sched[k];
      end else begin
        e.ready = 0; e.rvalid = 1; e.cmd = NO_OPERATION;
      end
      exp_a[(c0 + k) % 1024] = e;
    end

    req_funct3_i = f3; req_address_i = a; req_rs1_data_i = rs1; req_uimm_i = u;
    req_rd_zero_i = rdz; req_rs1_zero_i = rsz;
    last_rd = 'x; last_exc = 1'bx;
    for (int k = 0; k < end_k; k++) begin
      req_valid_i = (k == 0);
      flush_i     = (k == flush_at);
      rsp_ready_i = (k >= lat + bp);
      if (k == reset_at) begin
        #1 reset_ni = 1'b0;
        #1 check_reset_outputs("midop_reset");
        @(negedge clock_i);
        #1 reset_ni = 1'b1;
      end
      @(posedge clock_i);
      #1;
    end
    req_valid_i = 0; flush_i = 0; rsp_ready_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) exp_a[i].v = 0;
    #1 reset_ni = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clock_i);
    reset_ni = 1'b1;
    @(posedge clock_i);
    #1;

    do_req(CSRRW, 12'h340, 32'hDEADBEEF, 5'd0, 0, 0, 0, -1, -1);
    chk("lit_csrrw_rd", last_rd, 32'h0);
    chk("lit_csrrw_mem", csr_mem[12'h340], 32'hDEADBEEF);

    do_req(CSRRS, 12'h340, 32'h000000F0, 5'd0, 0, 0, 0, -1, -1);
    chk("lit_csrrs_rd", last_rd, 32'hDEADBEEF);
    chk("lit_csrrs_mem", csr_mem[12'h340], 32'hDEADBEFF);

    do_req(CSRRCI, 12'h340, 32'h0, 5'h0F, 0, 0, 0, -1, -1);
    chk("lit_csrrci_rd", last_rd, 32'hDEADBEFF);
    chk("lit_csrrci_mem", csr_mem[12'h340], 32'hDEADBEF0);

    do_req(CSRRS, 12'h7C0, 32'h0, 5'd0, 0, 1, 0, -1, -1);
    chk("lit_nonexistent_exc", 32'(last_exc), 32'd1);

    do_req(CSRRW, 12'hF14, 32'h0000FFFF, 5'd0, 1, 0, 0, -1, -1);
    chk("lit_ro_write_exc", 32'(last_exc), 32'd1);

    do_req(CSRRSI, 12'h340, 32'h0, 5'd0, 0, 1, 3, -1, -1);
    chk("lit_backpressure_rd", last_rd, 32'hDEADBEF0);

    do_req(3'b100, 12'h340, 32'h1, 5'd0, 0, 0, 0, -1, -1);
    chk("lit_illegal_exc", 32'(last_exc), 32'd1);

    do_req(CSRRW, 12'h340, 32'h0000AAAA, 5'd0, 0, 0, 0, 0, -1);
    do_req(CSRRW, 12'h340, 32'h12345678, 5'd0, 0, 0, 0, 2, -1);
    chk("lit_flush_no_write", csr_mem[12'h340], 32'hDEADBEF0);

    do_req(CSRRS, 12'h340, 32'h0, 5'd0, 0, 1, 0, -1, -1);
    chk("lit_after_flush_rd", last_rd, 32'hDEADBEF0);

    do_req(CSRRWI, 12'h305, 32'h0, 5'h1F, 1, 0, 0, -1, -1);
    chk("lit_csrrwi_mem", csr_mem[12'h305], 32'h0000001F);

    do_req(CSRRW, 12'h7C1, 32'h5, 5'd0, 1, 0, 1, -1, -1);
    do_req(CSRRC, 12'h305, 32'h3, 5'd0, 0, 0, 0, -1, -1);
    chk("lit_csrrc_mem", csr_mem[12'h305], 32'h0000001C);

    do_req(CSRRS, 12'h340, 32'h0000000F, 5'd0, 0, 0, 0, -1, 3);
    chk("lit_reset_no_write", csr_mem[12'h340], 32'hDEADBEF0);

    do_req(CSRRS, 12'h340, 32'h0, 5'd0, 0, 1, 0, -1, -1);
    chk("lit_after_reset_rd", last_rd, 32'hDEADBEF0);

    do_req(CSRRS, 12'hF14, 32'h0, 5'd0, 0, 1, 0, -1, -1);
    do_req(CSRRS, 12'hF14, 32'h1, 5'd0, 0, 0, 0, -1, -1);
    chk("lit_ro_rmw_exc", 32'(last_exc), 32'd1);

    repeat (2) @(posedge clock_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
